// File: rtl/c5_pkg.sv
// Shared c5 definitions: ALU function codes and the arbiter state encoding.
package c5;

  localparam logic [3:0] ALU_ADD              = 4'h0;
  localparam logic [3:0] ALU_SUBTRACT         = 4'h1;
  localparam logic [3:0] ALU_LESS_THAN        = 4'h2;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'h3;
  localparam logic [3:0] ALU_OR               = 4'h4;
  localparam logic [3:0] ALU_AND              = 4'h5;
  localparam logic [3:0] ALU_XOR              = 4'h6;
  localparam logic [3:0] ALU_NOR              = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/c5_alu.sv
// 32-bit combinational ALU; undefined function codes produce zero.
module c5_alu
  import c5::*;
(
  input  logic [31:0] I_a_in,
  input  logic [31:0] I_b_in,
  input  logic [3:0]  I_alu_function,
  output logic [31:0] O_c_alu
);

  always_comb begin
    O_c_alu = '0;
    case (I_alu_function)
      ALU_ADD:              O_c_alu = I_a_in + I_b_in;
      ALU_SUBTRACT:         O_c_alu = I_a_in - I_b_in;
      ALU_LESS_THAN:        O_c_alu = {31'b0, I_a_in < I_b_in};
      ALU_LESS_THAN_SIGNED: O_c_alu = {31'b0, $signed(I_a_in) < $signed(I_b_in)};
      ALU_OR:               O_c_alu = I_a_in | I_b_in;
      ALU_AND:              O_c_alu = I_a_in & I_b_in;
      ALU_XOR:              O_c_alu = I_a_in ^ I_b_in;
      ALU_NOR:              O_c_alu = ~(I_a_in | I_b_in);
      default:              O_c_alu = '0;
    endcase
  end

endmodule

// File: rtl/c5_alu_arbiter.sv
// Round-robin arbiter sharing one c5_alu among NREQ requesters;
// one operation in flight, IDLE -> EXEC -> RESP.
module c5_alu_arbiter
  import c5::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [NREQ-1:0]   I_req_valid,
  input  logic [NREQ*W-1:0] I_req_a,
  input  logic [NREQ*W-1:0] I_req_b,
  input  logic [NREQ*4-1:0] I_req_func,
  output logic [NREQ-1:0]   O_req_ready,
  output logic [NREQ-1:0]   O_rsp_valid,
  output logic [W-1:0]      O_rsp_data,
  input  logic [NREQ-1:0]   I_rsp_ready,
  output logic              O_busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state, state_nx;
  logic [IW-1:0]   rr_ptr, grant, winner;
  logic [W-1:0]    a_q, b_q, result_q, alu_c;
  logic [3:0]      func_q;
  logic            any_req, rsp_hs;
  logic [NREQ-1:0] one;

  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] pick;
    logic          found;
    logic [31:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && v[idx[IW-1:0]]) begin
        pick  = idx[IW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign one     = {{(NREQ-1){1'b0}}, 1'b1};
  assign any_req = |I_req_valid;
  assign winner  = rr_pick(I_req_valid, rr_ptr);
  assign rsp_hs  = (state == ST_RESP) && I_rsp_ready[grant];

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (any_req) state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: if (rsp_hs) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rr_ptr   <= '0;
      grant    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      func_q   <= '0;
      result_q <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        grant  <= winner;
        a_q    <= I_req_a[winner*W +: W];
        b_q    <= I_req_b[winner*4*0 + winner*W +: W];
        func_q <= I_req_func[winner*4 +: 4];
      end
      if (state == ST_EXEC) result_q <= alu_c;
      if (rsp_hs) rr_ptr <= (grant == IW'(NREQ-1)) ? '0 : grant + 1'b1;
    end
  end

  // Ready is gated by reset so a held request is never acknowledged during reset.
  always_comb begin
    O_req_ready = '0;
    O_rsp_valid = '0;
    O_busy      = (state != ST_IDLE);
    O_rsp_data  = result_q;
    case (state)
      ST_IDLE: if (any_req && I_rst_n) O_req_ready = one << winner;
      ST_RESP: O_rsp_valid = one << grant;
      default: ;
    endcase
  end

  c5_alu u_alu (
    .I_a_in         (a_q),
    .I_b_in         (b_q),
    .I_alu_function (func_q),
    .O_c_alu        (alu_c)
  );

endmodule
